branch_resolve_tracker: RTL and testbench

- Holds the in-flight branch predictions made at fetch/decode. Matches each prediction, in program order, against the resolved outcome from the execute stage.
- Generates the update write (updata_PC / updata_taken / updata_enable) into the branch history table.
- Generates the mispredict pulse and redirect PC for the fetch stage, and discards wrong-path entries.

---
 rtl/branch_resolve_tracker.sv | 117 +++++++++++
 tb/tb_branch_resolve_tracker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_tracker.sv
// In-order tracker of in-flight branch predictions: matches each against the
// execute-stage outcome, drives history-table updates and fetch redirects.
module branch_resolve_tracker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_push,
    input  logic [31:0]       dec_PC,
    input  logic              dec_pred_taken,
    input  logic [31:0]       dec_pred_target,
    input  logic              ex_resolve,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              flush,
    output logic [31:0]       updata_PC,
    output logic              updata_taken,
    output logic              updata_enable,
    output logic              mispredict,
    output logic [31:0]       redirect_PC,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              proto_err
);

    localparam int AW = (CNT_W > 1) ? CNT_W - 1 : 1;

    logic [31:0]      pc_mem  [DEPTH];
    logic             pt_mem  [DEPTH];
    logic [31:0]      tgt_mem [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic [31:0]      head_pc;
    logic             head_pt;
    logic [31:0]      head_tgt;
    logic             is_empty;
    logic             is_full;
    logic             do_pop;
    logic             miss;
    logic             hit;
    logic             push_ok;
    logic             push_err;
    logic             pop_err;
    logic [31:0]      redirect_next;

    always_comb begin
        head_pc  = pc_mem[rd_ptr];
        head_pt  = pt_mem[rd_ptr];
        head_tgt = tgt_mem[rd_ptr];
        is_empty = (cnt == '0);
        is_full  = (cnt == CNT_W'(DEPTH));
        do_pop   = ex_resolve & ~is_empty;
        miss     = do_pop & ((head_pt != ex_taken) |
                             (head_pt & ex_taken & (head_tgt != ex_target)));
        hit      = do_pop & ~miss;
        // A correct resolve frees the head slot in the same cycle, so a push
        // into a full queue is still accepted; wrong-path/flushed pushes are not.
        push_ok  = dec_push & ~flush & ~miss & (~is_full | hit);
        push_err = dec_push & ~flush & ~miss & is_full & ~hit;
        pop_err  = ex_resolve & is_empty;
        redirect_next = ex_taken ? ex_target : head_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_ptr]  <= dec_PC;
            pt_mem[wr_ptr]  <= dec_pred_taken;
            tgt_mem[wr_ptr] <= dec_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            updata_PC     <= '0;
            updata_taken  <= 1'b0;
            updata_enable <= 1'b0;
            mispredict    <= 1'b0;
            redirect_PC   <= '0;
            proto_err     <= 1'b0;
        end else begin
            if (miss || flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push_ok, do_pop})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
            updata_enable <= do_pop;
            mispredict    <= miss;
            if (do_pop) begin
                updata_PC    <= head_pc;
                updata_taken <= ex_taken;
            end
            if (miss) redirect_PC <= redirect_next;
            if (push_err || pop_err) proto_err <= 1'b1;
        end
    end

    assign count = cnt;
    assign full  = is_full;
    assign empty = is_empty;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed bench for branch_resolve_tracker: queue-based reference model checked
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_branch_resolve_tracker;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dec_push = 1'b0;
    logic [31:0] dec_PC = '0;
    logic        dec_pred_taken = 1'b0;
    logic [31:0] dec_pred_target = '0;
    logic        ex_resolve = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        flush = 1'b0;
    logic [31:0] updata_PC;
    logic        updata_taken;
    logic        updata_enable;
    logic        mispredict;
    logic [31:0] redirect_PC;
    logic [CNT_W-1:0] count;
    logic        full;
    logic        empty;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    branch_resolve_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .dec_push(dec_push), .dec_PC(dec_PC), .dec_pred_taken(dec_pred_taken),
        .dec_pred_target(dec_pred_target),
        .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
        .flush(flush),
        .updata_PC(updata_PC), .updata_taken(updata_taken), .updata_enable(updata_enable),
        .mispredict(mispredict), .redirect_PC(redirect_PC),
        .count(count), .full(full), .empty(empty), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of predictions, evaluated once per rising edge.
    typedef struct { logic [31:0] pc; logic pt; logic [31:0] tgt; } pred_t;
    pred_t q[$];
    logic        m_perr = 1'b0;
    logic        m_upd = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_upc = '0;
    logic        m_ut = 1'b0;
    logic [31:0] m_red = '0;

    task automatic model_step();
        pred_t h;
        bit pop, wrong, accept;
        m_upd = 1'b0;
        m_mis = 1'b0;
        wrong = 1'b0;
        if (!rst) begin
            q.delete();
            m_perr = 1'b0;
            m_upc = '0; m_ut = 1'b0; m_red = '0;
            return;
        end
        pop = ex_resolve && q.size() > 0;
        if (ex_resolve && q.size() == 0) m_perr = 1'b1;
        if (pop) begin
            h = q[0];
            wrong = (h.pt != ex_taken) || (ex_taken && h.pt && h.tgt != ex_target);
            m_upd = 1'b1;
            m_upc = h.pc;
            m_ut  = ex_taken;
            if (wrong) begin
                m_mis = 1'b1;
                m_red = ex_taken ? ex_target : h.pc + 32'd4;
            end
        end
        accept = dec_push && !flush && !wrong && (q.size() < DEPTH || pop);
        if (dec_push && !flush && !wrong && q.size() == DEPTH && !pop) m_perr = 1'b1;
        if (pop) void'(q.pop_front());
        if (wrong || flush) q.delete();
        else if (accept) q.push_back('{dec_PC, dec_pred_taken, dec_pred_target});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("proto_err", 32'(proto_err), 32'(m_perr));
            chk("updata_enable", 32'(updata_enable), 32'(m_upd));
            chk("mispredict", 32'(mispredict), 32'(m_mis));
            if (m_upd) begin
                chk("updata_PC", updata_PC, m_upc);
                chk("updata_taken", 32'(updata_taken), 32'(m_ut));
            end
            if (m_mis) chk("redirect_PC", redirect_PC, m_red);
        end
    end

    // Drive one cycle of stimulus (called just after a falling edge); returns at
    // the next falling edge, when that cycle's registered results are visible.
    task automatic cyc(input bit p, input logic [31:0] pc, input bit pt, input logic [31:0] pt_tgt,
                       input bit r, input bit tk, input logic [31:0] tgt, input bit fl);
        dec_push = p; dec_PC = pc; dec_pred_taken = pt; dec_pred_target = pt_tgt;
        ex_resolve = r; ex_taken = tk; ex_target = tgt; flush = fl;
        @(negedge clk);
        dec_push = 1'b0; ex_resolve = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input bit pt, input logic [31:0] pt_tgt);
        cyc(1, pc, pt, pt_tgt, 0, 0, 0, 0);
    endtask

    task automatic resolve(input bit tk, input logic [31:0] tgt);
        cyc(0, 0, 0, 0, 1, tk, tgt, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst count", 32'(count), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst full", 32'(full), 0);
        chk("rst proto_err", 32'(proto_err), 0);
        chk("rst updata_enable", 32'(updata_enable), 0);
        chk("rst mispredict", 32'(mispredict), 0);
        chk("rst updata_PC", updata_PC, 0);
        chk("rst redirect_PC", redirect_PC, 0);
        rst = 1'b1;
        @(negedge clk);

        // Correct not-taken prediction
        push(32'h100, 0, 0);
        chk("t1 count after push", 32'(count), 1);
        resolve(0, 32'h0);
        chk("t1 upd_en", 32'(updata_enable), 1);
        chk("t1 upd_PC", updata_PC, 32'h100);
        chk("t1 upd_taken", 32'(updata_taken), 0);
        chk("t1 mispredict", 32'(mispredict), 0);
        chk("t1 count", 32'(count), 0);
        @(negedge clk);
        chk("t1 upd_en one-shot", 32'(updata_enable), 0);

        // Direction mispredict discards the younger entry
        push(32'h200, 0, 0);
        push(32'h204, 0, 0);
        resolve(1, 32'h300);
        chk("t2 mispredict", 32'(mispredict), 1);
        chk("t2 redirect", redirect_PC, 32'h300);
        chk("t2 upd_taken", 32'(updata_taken), 1);
        chk("t2 count", 32'(count), 0);

        // Target mispredict, then direction mispredict to fall-through
        push(32'h400, 1, 32'h500);
        resolve(1, 32'h600);
        chk("t3 mispredict tgt", 32'(mispredict), 1);
        chk("t3 redirect tgt", redirect_PC, 32'h600);
        push(32'h400, 1, 32'h500);
        resolve(0, 32'h0);
        chk("t3 redirect ft", redirect_PC, 32'h404);
        push(32'hFFFF_FFFC, 1, 32'h40);
        resolve(0, 32'h0);
        chk("t3 redirect wrap", redirect_PC, 32'h0);

        // Fill, overflow push, push alongside a correct resolve, drain in order
        push(32'h10, 0, 0);
        push(32'h14, 0, 0);
        push(32'h18, 1, 32'h80);
        push(32'h1C, 0, 0);
        chk("t4 full", 32'(full), 1);
        chk("t4 perr clean", 32'(proto_err), 0);
        push(32'h20, 0, 0);
        chk("t4 overflow perr", 32'(proto_err), 1);
        chk("t4 overflow count", 32'(count), 4);
        cyc(1, 32'h24, 0, 0, 1, 0, 0, 0);
        chk("t4 concurrent upd_PC", updata_PC, 32'h10);
        chk("t4 concurrent count", 32'(count), 4);
        resolve(0, 0);
        chk("t4 drain0", updata_PC, 32'h14);
        resolve(1, 32'h80);
        chk("t4 drain1", updata_PC, 32'h18);
        chk("t4 drain1 hit", 32'(mispredict), 0);
        resolve(0, 0);
        chk("t4 drain2", updata_PC, 32'h1C);
        resolve(0, 0);
        chk("t4 drain3", updata_PC, 32'h24);
        resolve(0, 0);
        chk("t4 empty resolve upd_en", 32'(updata_enable), 0);
        chk("t4 empty count", 32'(count), 0);

        // Asynchronous reset with entries held
        push(32'h500, 0, 0);
        push(32'h504, 0, 0);
        push(32'h508, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("t5 async count", 32'(count), 0);
        chk("t5 async perr", 32'(proto_err), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        resolve(0, 0);
        chk("t5 empty resolve upd_en", 32'(updata_enable), 0);
        chk("t5 empty resolve perr", 32'(proto_err), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Wrong-path push into a full queue: dropped, no protocol error
        push(32'h600, 0, 0);
        push(32'h604, 0, 0);
        push(32'h608, 0, 0);
        push(32'h60C, 0, 0);
        cyc(1, 32'h610, 0, 0, 1, 1, 32'h900, 0);
        chk("t6 wrong-path count", 32'(count), 0);
        chk("t6 wrong-path perr", 32'(proto_err), 0);

        // Flush with a correct resolve and a push in the same cycle
        push(32'h700, 0, 0);
        push(32'h704, 0, 0);
        push(32'h708, 0, 0);
        cyc(1, 32'h70C, 0, 0, 1, 0, 0, 1);
        chk("t7 flush upd_en", 32'(updata_enable), 1);
        chk("t7 flush upd_PC", updata_PC, 32'h700);
        chk("t7 flush mispredict", 32'(mispredict), 0);
        chk("t7 flush count", 32'(count), 0);
        push(32'h800, 0, 0);
        resolve(0, 0);
        chk("t7 after flush upd_PC", updata_PC, 32'h800);
        chk("t7 perr still clear", 32'(proto_err), 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
